// File: rtl/sdram_arbiter.sv
// Arbitrates the SDRAM command bus between the write engine, the read engine and auto-refresh.
// Optional macro SDRAM_ARB_ROUND_ROBIN_EN: round-robin grants with release on contention.
//
// state        | meaning
// IDLE         | no owner; arbitrate or start refresh
// WRITE        | write engine granted
// READ         | read engine granted
// DRAIN_WR     | write grant dropped, waiting for write engine idle
// DRAIN_RD     | read grant dropped, waiting for read engine idle
// REF_PRE      | PRECHARGE-all issued
// REF_PRE_WAIT | tRP NOPs
// REF_CMD      | AUTO_REFRESH issued
// REF_WAIT     | tRFC NOPs
module sdram_arbiter #(
    parameter int REFRESH_CYCLES = 1560,
    parameter int T_RP_CYC       = 2,
    parameter int T_RFC_CYC      = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic        wr_idle,
    input  logic        rd_idle,
    input  logic [2:0]  wr_command,
    input  logic [11:0] wr_address,
    input  logic [1:0]  wr_bank,
    input  logic [2:0]  rd_command,
    input  logic [11:0] rd_address,
    input  logic [1:0]  rd_bank,
    output logic        wr_enable,
    output logic        rd_enable,
    output logic        auto_refresh,
    output logic [2:0]  command,
    output logic [11:0] address,
    output logic [1:0]  bank,
    output logic        busy
);

    localparam logic [2:0] SDRAM_CMD_NOP          = 3'b111;
    localparam logic [2:0] SDRAM_CMD_PRECHARGE    = 3'b010;
    localparam logic [2:0] SDRAM_CMD_AUTO_REFRESH = 3'b001;

    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFRESH_CYCLES - 1);
    localparam int T_MAX = (T_RFC_CYC > T_RP_CYC) ? T_RFC_CYC : T_RP_CYC;
    localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [TMR_W-1:0] TRP_LOAD  = TMR_W'(T_RP_CYC - 1);
    localparam logic [TMR_W-1:0] TRFC_LOAD = TMR_W'(T_RFC_CYC - 1);

    typedef enum logic [3:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN_WR,
        DRAIN_RD,
        REF_PRE,
        REF_PRE_WAIT,
        REF_CMD,
        REF_WAIT
    } state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   ref_cnt;
    logic               refresh_pending;
    logic [TMR_W-1:0]   tmr;
    logic [2:0]         ref_command;
    logic [11:0]        ref_address;
    logic               pick_wr;
    logic               wr_release;
    logic               rd_release;
    logic               ref_done;

    assign ref_done = (state == REF_WAIT) && (tmr == '0);

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic last_wr;

    assign pick_wr    = wr_req && (!rd_req || !last_wr);
    assign wr_release = rd_req && wr_idle;
    assign rd_release = wr_req && rd_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr <= 1'b0;
        end else if (state == IDLE && next_state == WRITE) begin
            last_wr <= 1'b1;
        end else if (state == IDLE && next_state == READ) begin
            last_wr <= 1'b0;
        end
    end
`else
    assign pick_wr    = wr_req;
    assign wr_release = 1'b0;
    assign rd_release = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!init_done) begin
                    next_state = IDLE;
                end else if (refresh_pending) begin
                    next_state = REF_PRE;
                end else if (pick_wr) begin
                    next_state = WRITE;
                end else if (rd_req) begin
                    next_state = READ;
                end
            end
            WRITE: begin
                if (!wr_req || refresh_pending || wr_release) next_state = DRAIN_WR;
            end
            READ: begin
                if (!rd_req || refresh_pending || rd_release) next_state = DRAIN_RD;
            end
            DRAIN_WR: begin
                if (wr_idle) next_state = refresh_pending ? REF_PRE : IDLE;
            end
            DRAIN_RD: begin
                if (rd_idle) next_state = refresh_pending ? REF_PRE : IDLE;
            end
            REF_PRE:      next_state = REF_PRE_WAIT;
            REF_PRE_WAIT: if (tmr == '0) next_state = REF_CMD;
            REF_CMD:      next_state = REF_WAIT;
            REF_WAIT:     if (tmr == '0) next_state = IDLE;
            default:      next_state = IDLE;
        endcase
    end

    // Refresh interval timer; holds until the SDRAM is initialised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt         <= CNT_RELOAD;
            refresh_pending <= 1'b0;
        end else begin
            if (!init_done || ref_cnt == '0) begin
                ref_cnt <= CNT_RELOAD;
            end else begin
                ref_cnt <= ref_cnt - 1'b1;
            end
            if (ref_done) begin
                refresh_pending <= 1'b0;
            end else if (init_done && ref_cnt == '0) begin
                refresh_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if (state == REF_PRE) begin
            tmr <= TRP_LOAD;
        end else if (state == REF_CMD) begin
            tmr <= TRFC_LOAD;
        end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end

    // Refresh commands are registered so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_command <= SDRAM_CMD_NOP;
            ref_address <= '0;
        end else begin
            case (next_state)
                REF_PRE: begin
                    ref_command <= SDRAM_CMD_PRECHARGE;
                    ref_address <= 12'h400;
                end
                REF_CMD: begin
                    ref_command <= SDRAM_CMD_AUTO_REFRESH;
                    ref_address <= '0;
                end
                default: begin
                    ref_command <= SDRAM_CMD_NOP;
                    ref_address <= '0;
                end
            endcase
        end
    end

    always_comb begin
        command = SDRAM_CMD_NOP;
        address = '0;
        bank    = '0;
        case (state)
            WRITE, DRAIN_WR: begin
                command = wr_command;
                address = wr_address;
                bank    = wr_bank;
            end
            READ, DRAIN_RD: begin
                command = rd_command;
                address = rd_address;
                bank    = rd_bank;
            end
            REF_PRE, REF_PRE_WAIT, REF_CMD, REF_WAIT: begin
                command = ref_command;
                address = ref_address;
            end
            default: ;
        endcase
    end

    // Gating on pending keeps grants off in the cycle the refresh request lands.
    assign wr_enable    = (state == WRITE) && !refresh_pending;
    assign rd_enable    = (state == READ) && !refresh_pending;
    assign auto_refresh = refresh_pending;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: every change of the output bundle is matched
// against a queue of expected (cycle, outputs) events pushed by the stimulus.
module tb_sdram_arbiter;

    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] RDC = 3'b101;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] ARF = 3'b001;

    logic        clk;
    logic        rst_n;
    logic        init_done;
    logic        wr_req, rd_req, wr_idle, rd_idle;
    logic [2:0]  wr_command, rd_command;
    logic [11:0] wr_address, rd_address;
    logic [1:0]  wr_bank, rd_bank;
    logic        wr_enable, rd_enable, auto_refresh, busy;
    logic [2:0]  command;
    logic [11:0] address;
    logic [1:0]  bank;

    sdram_arbiter #(
        .REFRESH_CYCLES(40),
        .T_RP_CYC(2),
        .T_RFC_CYC(7)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .init_done(init_done),
        .wr_req(wr_req),
        .rd_req(rd_req),
        .wr_idle(wr_idle),
        .rd_idle(rd_idle),
        .wr_command(wr_command),
        .wr_address(wr_address),
        .wr_bank(wr_bank),
        .rd_command(rd_command),
        .rd_address(rd_address),
        .rd_bank(rd_bank),
        .wr_enable(wr_enable),
        .rd_enable(rd_enable),
        .auto_refresh(auto_refresh),
        .command(command),
        .address(address),
        .bank(bank),
        .busy(busy)
    );

    typedef struct {
        int          cyc;
        logic [20:0] obs;
    } ev_t;

    ev_t         exp_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [20:0] prev_obs;
    logic [20:0] cur_obs;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [20:0] mk(input logic we, input logic re, input logic ar,
                                       input logic bz, input logic [2:0] cmd,
                                       input logic [11:0] a, input logic [1:0] b);
        return {we, re, ar, bz, cmd, a, b};
    endfunction

    task automatic expect_ev(input int c, input logic [20:0] o);
        ev_t e;
        e.cyc = c;
        e.obs = o;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: any change of the output bundle must match the next expected event.
    always @(negedge clk) begin
        ev_t e;
        cur_obs = {wr_enable, rd_enable, auto_refresh, busy, command, address, bank};
        if (cur_obs !== prev_obs) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: cycle %0d outputs %h, none expected", cyc, cur_obs);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.obs !== cur_obs) begin
                    errors++;
                    $display("FAIL event: got cycle %0d outputs %h, expected cycle %0d outputs %h",
                             cyc, cur_obs, e.cyc, e.obs);
                end
            end
        end
        prev_obs = cur_obs;
    end

    initial begin
        int t;
        rst_n      = 1'b0;
        init_done  = 1'b0;
        wr_req     = 1'b0;
        rd_req     = 1'b0;
        wr_idle    = 1'b1;
        rd_idle    = 1'b1;
        wr_command = ACT;
        wr_address = 12'h123;
        wr_bank    = 2'd1;
        rd_command = RDC;
        rd_address = 12'h2A5;
        rd_bank    = 2'd2;
        expect_ev(1, mk(0, 0, 0, 0, NOP, 12'h000, 2'd0));
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Not initialised: a pending write must not be granted, no refresh.
        wr_req = 1'b1;
        tick(3000);
        wr_req = 1'b0;
        tick(2);

        // Both engines requesting constantly with idle pulses.
        t = cyc;
        expect_ev(t + 1, mk(1, 0, 0, 1, ACT, 12'h123, 2'd1));
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        expect_ev(t + 4,  mk(0, 0, 0, 1, ACT, 12'h123, 2'd1));
        expect_ev(t + 5,  mk(0, 0, 0, 0, NOP, 12'h000, 2'd0));
        expect_ev(t + 6,  mk(0, 1, 0, 1, RDC, 12'h2A5, 2'd2));
        expect_ev(t + 9,  mk(0, 0, 0, 1, RDC, 12'h2A5, 2'd2));
        expect_ev(t + 10, mk(0, 0, 0, 0, NOP, 12'h000, 2'd0));
        expect_ev(t + 11, mk(1, 0, 0, 1, ACT, 12'h123, 2'd1));
`endif
        expect_ev(t + 14, mk(0, 0, 0, 1, ACT, 12'h123, 2'd1));
        expect_ev(t + 15, mk(0, 0, 0, 0, NOP, 12'h000, 2'd0));
        init_done = 1'b1;
        wr_req    = 1'b1;
        rd_req    = 1'b1;
        wr_idle   = 1'b0;
        rd_idle   = 1'b0;
        tick(3);
        wr_idle = 1'b1;
        tick(2);
        wr_idle = 1'b0;
        tick(3);
        rd_idle = 1'b1;
        tick(2);
        rd_idle = 1'b0;
        tick(3);
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_idle = 1'b1;
        rd_idle = 1'b1;
        tick(4);
        init_done = 1'b0;
        tick(3);

        // Refresh expiry during a write with the engine still busy.
        t = cyc;
        expect_ev(t + 1,  mk(1, 0, 0, 1, ACT, 12'h123, 2'd1));
        expect_ev(t + 40, mk(0, 0, 1, 1, ACT, 12'h123, 2'd1));
        expect_ev(t + 45, mk(0, 0, 1, 1, PRE, 12'h400, 2'd0));
        expect_ev(t + 46, mk(0, 0, 1, 1, NOP, 12'h000, 2'd0));
        expect_ev(t + 48, mk(0, 0, 1, 1, ARF, 12'h000, 2'd0));
        expect_ev(t + 49, mk(0, 0, 1, 1, NOP, 12'h000, 2'd0));
        expect_ev(t + 56, mk(0, 0, 0, 0, NOP, 12'h000, 2'd0));
        init_done = 1'b1;
        wr_req    = 1'b1;
        wr_idle   = 1'b0;
        tick(44);
        wr_idle = 1'b1;
        wr_req  = 1'b0;
        tick(16);
        init_done = 1'b0;
        tick(3);

        // Read-only request.
        t = cyc;
        expect_ev(t + 1, mk(0, 1, 0, 1, RDC, 12'h2A5, 2'd2));
        expect_ev(t + 4, mk(0, 0, 0, 1, RDC, 12'h2A5, 2'd2));
        expect_ev(t + 5, mk(0, 0, 0, 0, NOP, 12'h000, 2'd0));
        init_done = 1'b1;
        rd_req    = 1'b1;
        rd_idle   = 1'b0;
        tick(3);
        rd_req  = 1'b0;
        rd_idle = 1'b1;
        tick(4);
        init_done = 1'b0;
        tick(3);

        // Long read drain spanning two counter expiries: only one refresh runs.
        t = cyc;
        expect_ev(t + 1,  mk(0, 1, 0, 1, RDC, 12'h2A5, 2'd2));
        expect_ev(t + 40, mk(0, 0, 1, 1, RDC, 12'h2A5, 2'd2));
        expect_ev(t + 85, mk(0, 0, 1, 1, PRE, 12'h400, 2'd0));
        expect_ev(t + 86, mk(0, 0, 1, 1, NOP, 12'h000, 2'd0));
        expect_ev(t + 88, mk(0, 0, 1, 1, ARF, 12'h000, 2'd0));
        expect_ev(t + 89, mk(0, 0, 1, 1, NOP, 12'h000, 2'd0));
        expect_ev(t + 96, mk(0, 0, 0, 0, NOP, 12'h000, 2'd0));
        init_done = 1'b1;
        rd_req    = 1'b1;
        rd_idle   = 1'b0;
        tick(84);
        rd_idle = 1'b1;
        rd_req  = 1'b0;
        tick(16);
        init_done = 1'b0;
        tick(3);

        // Refresh from IDLE, reset asserted in REF_WAIT, then a fresh interval.
        t = cyc;
        expect_ev(t + 40, mk(0, 0, 1, 0, NOP, 12'h000, 2'd0));
        expect_ev(t + 41, mk(0, 0, 1, 1, PRE, 12'h400, 2'd0));
        expect_ev(t + 42, mk(0, 0, 1, 1, NOP, 12'h000, 2'd0));
        expect_ev(t + 44, mk(0, 0, 1, 1, ARF, 12'h000, 2'd0));
        expect_ev(t + 45, mk(0, 0, 1, 1, NOP, 12'h000, 2'd0));
        expect_ev(t + 47, mk(0, 0, 0, 0, NOP, 12'h000, 2'd0));
        init_done = 1'b1;
        tick(47);
        rst_n     = 1'b0;
        init_done = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        t = cyc;
        expect_ev(t + 40, mk(0, 0, 1, 0, NOP, 12'h000, 2'd0));
        expect_ev(t + 41, mk(0, 0, 1, 1, PRE, 12'h400, 2'd0));
        expect_ev(t + 42, mk(0, 0, 1, 1, NOP, 12'h000, 2'd0));
        expect_ev(t + 44, mk(0, 0, 1, 1, ARF, 12'h000, 2'd0));
        expect_ev(t + 45, mk(0, 0, 1, 1, NOP, 12'h000, 2'd0));
        expect_ev(t + 52, mk(0, 0, 0, 0, NOP, 12'h000, 2'd0));
        init_done = 1'b1;
        tick(54);
        init_done = 1'b0;
        tick(5);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected events never seen, next expected at cycle %0d",
                     exp_q.size(), exp_q[0].cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
